// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sisc_pkg
// Description : Shared definitions for the SISC multicycle controller:
//               opcode values, the immediate addressing mode, the FSM state
//               encoding and the alu_op / wb_sel output codes.
// Revision    : 1.0 - initial release
// ============================================================================
package sisc_pkg;

    // Opcode values. Kept as plain integers so each user can cast them to
    // its own OPW-wide opcode field.
    localparam int unsigned OP_NOOP = 0;
    localparam int unsigned OP_LOD  = 1;
    localparam int unsigned OP_STR  = 2;
    localparam int unsigned OP_SWP  = 3;
    localparam int unsigned OP_BRA  = 4;
    localparam int unsigned OP_BRR  = 5;
    localparam int unsigned OP_BNE  = 6;
    localparam int unsigned OP_BNR  = 7;
    localparam int unsigned OP_ALU  = 8;
    localparam int unsigned OP_HLT  = 15;

    // mm value that selects the immediate operand for ALU instructions
    localparam int unsigned AM_IMM  = 8;

    // Controller states, 3-bit encoding
    typedef enum logic [2:0] {
        S_START1  = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_WB2     = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    // alu_op codes
    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_IMM  = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;

    // wb_sel codes
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_SWP   = 2'b10;

endpackage : sisc_pkg
`default_nettype wire

// File: rtl/sisc_br_cond.sv
`default_nettype none
// ============================================================================
// Module      : sisc_br_cond
// Description : Combinational branch-condition evaluator. A branch "hits"
//               when any masked status flag is set; BRA/BRR are taken on a
//               hit, BNE/BNR on a miss. Non-branch opcodes are never taken.
// Ports       : i_opcode [OPW]  latched opcode
//               i_mm     [MMW]  branch mask
//               i_stat   [MMW]  status flags
//               o_taken         branch is taken
//               o_br_sel        1 = absolute target (BRA/BNE), 0 = relative
// Revision    : 1.0 - initial release
// ============================================================================
module sisc_br_cond
    import sisc_pkg::*;
#(
    parameter int OPW = 4,
    parameter int MMW = 4
) (
    input  logic [OPW-1:0] i_opcode,
    input  logic [MMW-1:0] i_mm,
    input  logic [MMW-1:0] i_stat,
    output logic           o_taken,
    output logic           o_br_sel
);

    logic w_hit;

    assign w_hit = |(i_mm & i_stat);

    always_comb begin
        o_taken  = 1'b0;
        o_br_sel = 1'b0;
        if (i_opcode == OPW'(OP_BRA)) begin
            o_taken  = w_hit;
            o_br_sel = 1'b1;
        end else if (i_opcode == OPW'(OP_BRR)) begin
            o_taken  = w_hit;
        end else if (i_opcode == OPW'(OP_BNE)) begin
            o_taken  = ~w_hit;
            o_br_sel = 1'b1;
        end else if (i_opcode == OPW'(OP_BNR)) begin
            o_taken  = ~w_hit;
        end
    end

endmodule : sisc_br_cond
`default_nettype wire

// File: rtl/sisc_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : sisc_ctrl_mc
// Description : Multicycle control FSM for the SISC datapath. Sequences
//               fetch/decode/execute/mem/writeback for ALU, LOD, STR, SWP,
//               the four branch forms and HLT. Memory accesses wait on a
//               ready handshake with a timeout that halts with a sticky err.
// Ports       : clk, rst_f (async, active low)
//               opcode/mm   IR fields; stat status flags; mem_rdy from memory
//               ir_load, pc_write, pc_sel, br_sel, pc_rst   PC / IR control
//               rd_sel, alu_op, stat_en                     operand / ALU
//               dm_re, dm_we                                data memory
//               rf_we, wb_sel                               writeback
//               halted, err                                 status
// Revision    : 1.0 - initial release
// ============================================================================
module sisc_ctrl_mc
    import sisc_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int MMW    = 4,
    parameter int MEM_TO = 15
) (
    input  logic           clk,
    input  logic           rst_f,
    input  logic [OPW-1:0] opcode,
    input  logic [MMW-1:0] mm,
    input  logic [MMW-1:0] stat,
    input  logic           mem_rdy,
    output logic           ir_load,
    output logic           pc_write,
    output logic           pc_sel,
    output logic           br_sel,
    output logic           pc_rst,
    output logic [1:0]     rd_sel,
    output logic [1:0]     alu_op,
    output logic           stat_en,
    output logic           dm_re,
    output logic           dm_we,
    output logic           rf_we,
    output logic [1:0]     wb_sel,
    output logic           halted,
    output logic           err
);

    localparam int             c_CW      = $clog2(MEM_TO + 1);
    // Last wait cycle: a miss here means MEM_TO cycles have gone by unserved
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(MEM_TO - 1);

    state_t           r_state;
    state_t           w_next;
    logic [OPW-1:0]   r_op;
    logic [MMW-1:0]   r_mm;
    logic [c_CW-1:0]  r_tmo;
    logic             r_err;
    logic             w_taken;
    logic             w_br_sel;
    logic             w_timeout;

    sisc_br_cond #(
        .OPW (OPW),
        .MMW (MMW)
    ) u_br_cond (
        .i_opcode (r_op),
        .i_mm     (r_mm),
        .i_stat   (stat),
        .o_taken  (w_taken),
        .o_br_sel (w_br_sel)
    );

    // mem_rdy in the final wait cycle wins over the timeout
    assign w_timeout = (r_state == S_MEM) && !mem_rdy && (r_tmo == c_TO_LAST);
    assign err       = r_err;

    // State register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= S_START1;
        end else begin
            r_state <= w_next;
        end
    end

    // Latched instruction fields, timeout counter and sticky error
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_op  <= '0;
            r_mm  <= '0;
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_DECODE) begin
                r_op <= opcode;
                r_mm <= mm;
            end
            // Clearing in EXECUTE means the count starts at zero on MEM entry
            if (r_state == S_EXECUTE) begin
                r_tmo <= '0;
            end else if (r_state == S_MEM && !mem_rdy && !w_timeout) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next   = r_state;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_rst   = 1'b0;
        rd_sel   = 2'b00;
        alu_op   = ALU_RR;
        stat_en  = 1'b0;
        dm_re    = 1'b0;
        dm_we    = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        halted   = 1'b0;

        case (r_state)
            S_START1: begin
                pc_rst = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                w_next   = S_DECODE;
            end
            S_DECODE: begin
                // Operand B select comes from the live IR, ahead of the latch
                if (opcode == OPW'(OP_ALU) && mm == MMW'(AM_IMM)) begin
                    rd_sel = 2'b01;
                end else if (opcode == OPW'(OP_STR) || opcode == OPW'(OP_SWP)) begin
                    rd_sel = 2'b10;
                end
                w_next = (opcode == OPW'(OP_HLT)) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (r_op == OPW'(OP_ALU)) begin
                    alu_op  = (r_mm == MMW'(AM_IMM)) ? ALU_IMM : ALU_RR;
                    stat_en = 1'b1;
                    w_next  = S_WB;
                end else if (r_op == OPW'(OP_LOD) || r_op == OPW'(OP_STR)) begin
                    alu_op = ALU_ADDR;
                    w_next = S_MEM;
                end else if (r_op == OPW'(OP_SWP)) begin
                    w_next = S_WB;
                end else begin
                    // Branches, NOOP and undefined opcodes all return to FETCH
                    if (w_taken) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                        br_sel   = w_br_sel;
                    end
                    w_next = S_FETCH;
                end
            end
            S_MEM: begin
                if (r_op == OPW'(OP_LOD)) begin
                    dm_re = 1'b1;
                end else begin
                    dm_we = 1'b1;
                end
                if (mem_rdy) begin
                    w_next = (r_op == OPW'(OP_LOD)) ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_WB: begin
                rf_we = 1'b1;
                if (r_op == OPW'(OP_LOD)) begin
                    wb_sel = WB_MEM;
                    w_next = S_FETCH;
                end else if (r_op == OPW'(OP_SWP)) begin
                    wb_sel = WB_SWP;
                    w_next = S_WB2;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_WB2: begin
                rf_we  = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_START1;
            end
        endcase
    end

endmodule : sisc_ctrl_mc
`default_nettype wire

// File: tb/tb_sisc_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sisc_ctrl_mc
// Description : Self-checking bench for sisc_ctrl_mc. Each stimulus cycle
//               pushes the hand-derived output vector for that cycle into a
//               scoreboard; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sisc_ctrl_mc;

    // Output vector bit positions:
    // {ir_load,pc_write,pc_sel,br_sel,pc_rst,rd_sel[1:0],alu_op[1:0],
    //  stat_en,dm_re,dm_we,rf_we,wb_sel[1:0],halted,err}
    localparam logic [16:0] c_IRL   = 17'h10000;
    localparam logic [16:0] c_PCW   = 17'h08000;
    localparam logic [16:0] c_PCSEL = 17'h04000;
    localparam logic [16:0] c_BRSEL = 17'h02000;
    localparam logic [16:0] c_PCRST = 17'h01000;
    localparam logic [16:0] c_RD01  = 17'h00400;
    localparam logic [16:0] c_RD10  = 17'h00800;
    localparam logic [16:0] c_ALU01 = 17'h00100;
    localparam logic [16:0] c_ALU10 = 17'h00200;
    localparam logic [16:0] c_STEN  = 17'h00080;
    localparam logic [16:0] c_DMRE  = 17'h00040;
    localparam logic [16:0] c_DMWE  = 17'h00020;
    localparam logic [16:0] c_RFWE  = 17'h00010;
    localparam logic [16:0] c_WB01  = 17'h00004;
    localparam logic [16:0] c_WB10  = 17'h00008;
    localparam logic [16:0] c_HALT  = 17'h00002;
    localparam logic [16:0] c_ERR   = 17'h00001;
    localparam logic [16:0] c_NONE  = 17'h00000;
    localparam logic [16:0] c_F     = c_IRL | c_PCW;

    logic       clk;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       mem_rdy;
    logic       ir_load, pc_write, pc_sel, br_sel, pc_rst;
    logic [1:0] rd_sel, alu_op, wb_sel;
    logic       stat_en, dm_re, dm_we, rf_we, halted, err;
    logic [16:0] w_act;

    string       nq[$];
    logic [16:0] vq[$];
    int          n_cmp;
    int          n_err;

    sisc_ctrl_mc #(
        .OPW    (4),
        .MMW    (4),
        .MEM_TO (15)
    ) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .mem_rdy  (mem_rdy),
        .ir_load  (ir_load),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .pc_rst   (pc_rst),
        .rd_sel   (rd_sel),
        .alu_op   (alu_op),
        .stat_en  (stat_en),
        .dm_re    (dm_re),
        .dm_we    (dm_we),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .halted   (halted),
        .err      (err)
    );

    assign w_act = {ir_load, pc_write, pc_sel, br_sel, pc_rst, rd_sel, alu_op,
                    stat_en, dm_re, dm_we, rf_we, wb_sel, halted, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected vector per stimulus cycle, checked mid-cycle
    initial begin
        string       nm;
        logic [16:0] ev;
        n_cmp = 0;
        n_err = 0;
        forever begin
            @(negedge clk);
            if (vq.size() > 0) begin
                ev = vq.pop_front();
                nm = nq.pop_front();
                n_cmp++;
                if (w_act !== ev) begin
                    n_err++;
                    $display("FAIL %s: got %b expected %b", nm, w_act, ev);
                end
            end
        end
    end

    // Drive one cycle of inputs and record the outputs expected in it
    task automatic cyc(input string nm, input logic rst, input logic [3:0] op,
                       input logic [3:0] mv, input logic [3:0] sv,
                       input logic rdy, input logic [16:0] e);
        rst_f   = rst;
        opcode  = op;
        mm      = mv;
        stat    = sv;
        mem_rdy = rdy;
        nq.push_back(nm);
        vq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic s(input string nm, input logic [3:0] op, input logic [3:0] mv,
                     input logic [3:0] sv, input logic rdy, input logic [16:0] e);
        cyc(nm, 1'b1, op, mv, sv, rdy, e);
    endtask

    initial begin
        rst_f   = 1'b0;
        opcode  = '0;
        mm      = '0;
        stat    = '0;
        mem_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Reset and first fetch
        cyc("rst0", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, c_PCRST);
        cyc("rst1", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, c_PCRST);
        s("start1", 4'd8, 4'd8, 4'd0, 1'b0, c_PCRST);

        // ALU immediate: FETCH to FETCH in 4 cycles
        s("alui_f",  4'd8, 4'd8, 4'd0, 1'b0, c_F);
        s("alui_d",  4'd8, 4'd8, 4'd0, 1'b0, c_RD01);
        s("alui_e",  4'd8, 4'd8, 4'd0, 1'b0, c_ALU01 | c_STEN);
        s("alui_wb", 4'd8, 4'd8, 4'd0, 1'b0, c_RFWE);

        // ALU register/register
        s("alur_f",  4'd8, 4'd3, 4'd0, 1'b0, c_F);
        s("alur_d",  4'd8, 4'd3, 4'd0, 1'b0, c_NONE);
        s("alur_e",  4'd8, 4'd3, 4'd0, 1'b0, c_STEN);
        s("alur_wb", 4'd8, 4'd3, 4'd0, 1'b0, c_RFWE);

        // BRR taken (relative)
        s("brr_f", 4'd5, 4'd4, 4'd4, 1'b0, c_F);
        s("brr_d", 4'd5, 4'd4, 4'd4, 1'b0, c_NONE);
        s("brr_e", 4'd5, 4'd4, 4'd4, 1'b0, c_PCW | c_PCSEL);

        // BNE with a hit: not taken
        s("bne_f", 4'd6, 4'd2, 4'd2, 1'b0, c_F);
        s("bne_d", 4'd6, 4'd2, 4'd2, 1'b0, c_NONE);
        s("bne_e", 4'd6, 4'd2, 4'd2, 1'b0, c_NONE);

        // BRA taken (absolute)
        s("bra_f", 4'd4, 4'd8, 4'd9, 1'b0, c_F);
        s("bra_d", 4'd4, 4'd8, 4'd9, 1'b0, c_NONE);
        s("bra_e", 4'd4, 4'd8, 4'd9, 1'b0, c_PCW | c_PCSEL | c_BRSEL);

        // BNR with no hit: taken, relative
        s("bnr_f", 4'd7, 4'd1, 4'd6, 1'b0, c_F);
        s("bnr_d", 4'd7, 4'd1, 4'd6, 1'b0, c_NONE);
        s("bnr_e", 4'd7, 4'd1, 4'd6, 1'b0, c_PCW | c_PCSEL);

        // NOOP
        s("noop_f", 4'd0, 4'd0, 4'd0, 1'b0, c_F);
        s("noop_d", 4'd0, 4'd0, 4'd0, 1'b0, c_NONE);
        s("noop_e", 4'd0, 4'd0, 4'd0, 1'b0, c_NONE);

        // LOD with three wait cycles
        s("lod_f", 4'd1, 4'd0, 4'd0, 1'b0, c_F);
        s("lod_d", 4'd1, 4'd0, 4'd0, 1'b0, c_NONE);
        s("lod_e", 4'd1, 4'd0, 4'd0, 1'b0, c_ALU10);
        for (int i = 0; i < 3; i++) s("lod_wait", 4'd1, 4'd0, 4'd0, 1'b0, c_DMRE);
        s("lod_rdy", 4'd1, 4'd0, 4'd0, 1'b1, c_DMRE);
        s("lod_wb",  4'd1, 4'd0, 4'd0, 1'b0, c_RFWE | c_WB01);

        // STR with one wait cycle: no writeback
        s("str_f", 4'd2, 4'd0, 4'd0, 1'b0, c_F);
        s("str_d", 4'd2, 4'd0, 4'd0, 1'b0, c_RD10);
        s("str_e", 4'd2, 4'd0, 4'd0, 1'b0, c_ALU10);
        s("str_wait", 4'd2, 4'd0, 4'd0, 1'b0, c_DMWE);
        s("str_rdy",  4'd2, 4'd0, 4'd0, 1'b1, c_DMWE);

        // LOD where mem_rdy arrives in the final allowed wait cycle
        s("lodto_f", 4'd1, 4'd0, 4'd0, 1'b0, c_F);
        s("lodto_d", 4'd1, 4'd0, 4'd0, 1'b0, c_NONE);
        s("lodto_e", 4'd1, 4'd0, 4'd0, 1'b0, c_ALU10);
        for (int i = 0; i < 14; i++) s("lodto_wait", 4'd1, 4'd0, 4'd0, 1'b0, c_DMRE);
        s("lodto_rdy", 4'd1, 4'd0, 4'd0, 1'b1, c_DMRE);
        s("lodto_wb",  4'd1, 4'd0, 4'd0, 1'b0, c_RFWE | c_WB01);

        // SWP: two writeback cycles
        s("swp_f",   4'd3, 4'd0, 4'd0, 1'b0, c_F);
        s("swp_d",   4'd3, 4'd0, 4'd0, 1'b0, c_RD10);
        s("swp_e",   4'd3, 4'd0, 4'd0, 1'b0, c_NONE);
        s("swp_wb",  4'd3, 4'd0, 4'd0, 1'b0, c_RFWE | c_WB10);
        s("swp_wb2", 4'd3, 4'd0, 4'd0, 1'b0, c_RFWE);

        // STR timeout: 15 unserved MEM cycles, then sticky halt with err
        s("sto_f", 4'd2, 4'd0, 4'd0, 1'b0, c_F);
        s("sto_d", 4'd2, 4'd0, 4'd0, 1'b0, c_RD10);
        s("sto_e", 4'd2, 4'd0, 4'd0, 1'b0, c_ALU10);
        for (int i = 0; i < 15; i++) s("sto_wait", 4'd2, 4'd0, 4'd0, 1'b0, c_DMWE);
        s("sto_halt",  4'd2, 4'd0, 4'd0, 1'b0, c_HALT | c_ERR);
        s("sto_stay",  4'd2, 4'd0, 4'd0, 1'b1, c_HALT | c_ERR);
        s("sto_stay2", 4'd8, 4'd8, 4'd0, 1'b1, c_HALT | c_ERR);
        cyc("sto_rst", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, c_PCRST);
        s("sto_start1", 4'd15, 4'd0, 4'd0, 1'b0, c_PCRST);

        // HLT: halt without err
        s("hlt_f",    4'd15, 4'd0, 4'd0, 1'b0, c_F);
        s("hlt_d",    4'd15, 4'd0, 4'd0, 1'b0, c_NONE);
        s("hlt_halt", 4'd15, 4'd0, 4'd0, 1'b0, c_HALT);
        s("hlt_stay", 4'd15, 4'd0, 4'd0, 1'b0, c_HALT);
        cyc("hlt_rst", 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, c_PCRST);
        s("hlt_start1", 4'd3, 4'd0, 4'd0, 1'b0, c_PCRST);

        // SWP with reset dropped during WB2: START1 within the same cycle
        s("swpr_f",  4'd3, 4'd0, 4'd0, 1'b0, c_F);
        s("swpr_d",  4'd3, 4'd0, 4'd0, 1'b0, c_RD10);
        s("swpr_e",  4'd3, 4'd0, 4'd0, 1'b0, c_NONE);
        s("swpr_wb", 4'd3, 4'd0, 4'd0, 1'b0, c_RFWE | c_WB10);
        cyc("swpr_rst", 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, c_PCRST);
        s("swpr_start1", 4'd0, 4'd0, 4'd0, 1'b0, c_PCRST);
        s("swpr_fetch",  4'd0, 4'd0, 4'd0, 1'b0, c_F);

        // Let the monitor drain the last entry
        repeat (2) @(posedge clk);
        n_cmp++;
        if (vq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", vq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sisc_ctrl_mc
`default_nettype wire
